matrixmul_3_sdiv_32s_32s_32_seq: RTL and testbench

- Iterative signed divider: the inverse datapath to the matrixmul_3 signed multiplier cores.
- Computes quotient = din0 / din1 and remainder = din0 % din1 with C truncation semantics (round toward zero).
- Uses radix-2 restoring division, one bit per cycle.
- Used by matrixmul_3 normalisation/scaling stages; valid/ready on input, valid/ack on output, global ce stall like the multiplier cores.

---
 rtl/matrixmul_3_sdiv_32s_32s_32_seq_if.sv | 35 +++
 rtl/matrixmul_3_sdiv_32s_32s_32_seq.sv | 135 +++++++++++++
 tb/tb_matrixmul_3_sdiv_32s_32s_32_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/matrixmul_3_sdiv_32s_32s_32_seq_if.sv
// Operand/result bus for the matrixmul_3 iterative signed divider.
// The rem signal is present only when MATRIXMUL_3_SDIV_REM_EN is defined.
interface matrixmul_3_sdiv_32s_32s_32_seq_if #(
    parameter int WIDTH = 32
);
    // Handshake: operands move on an edge where din_vld && din_rdy (ce=1);
    // a result moves on an edge where dout_vld && dout_ack (ce=1).
    logic             din_vld;
    logic             din_rdy;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic             dout_vld;
    logic             dout_ack;
    logic [WIDTH-1:0] quot;
`ifdef MATRIXMUL_3_SDIV_REM_EN
    logic [WIDTH-1:0] rem;
`endif
    logic             div0;

    modport slave (
        input  din_vld, din0, din1, dout_ack,
        output din_rdy, dout_vld, quot, div0
`ifdef MATRIXMUL_3_SDIV_REM_EN
        , output rem
`endif
    );

    modport master (
        output din_vld, din0, din1, dout_ack,
        input  din_rdy, dout_vld, quot, div0
`ifdef MATRIXMUL_3_SDIV_REM_EN
        , input rem
`endif
    );
endinterface

// File: rtl/matrixmul_3_sdiv_32s_32s_32_seq.sv
// Radix-2 restoring signed divider (truncating), one quotient bit per cycle.
// Define MATRIXMUL_3_SDIV_REM_EN to build the remainder output.
module matrixmul_3_sdiv_32s_32s_32_seq #(
    parameter int ID    = 1,
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    matrixmul_3_sdiv_32s_32s_32_seq_if.slave bus,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;      // shifts out the dividend, shifts in quotient bits
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] prem;
    logic             neg_q;
    logic             neg_r;
    logic             zero_b;
    logic             rdy_r;
    logic             vld_r;
    logic [WIDTH-1:0] quot_r;
    logic             div0_r;
`ifdef MATRIXMUL_3_SDIV_REM_EN
    logic [WIDTH-1:0] rem_r;
`endif

    logic [WIDTH-1:0] abs0;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        abs0    = bus.din0[WIDTH-1] ? (~bus.din0 + 1'b1) : bus.din0;
        abs1    = bus.din1[WIDTH-1] ? (~bus.din1 + 1'b1) : bus.din1;
        shifted = {prem, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            prem   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            zero_b <= 1'b0;
            rdy_r  <= 1'b1;
            vld_r  <= 1'b0;
            quot_r <= '0;
            div0_r <= 1'b0;
`ifdef MATRIXMUL_3_SDIV_REM_EN
            rem_r  <= '0;
`endif
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (bus.din_vld) begin
                        dvd    <= abs0;
                        dvs    <= abs1;
                        neg_q  <= bus.din0[WIDTH-1] ^ bus.din1[WIDTH-1];
                        neg_r  <= bus.din0[WIDTH-1];
                        zero_b <= (bus.din1 == '0);
                        prem   <= '0;
                        cnt    <= '0;
                        rdy_r  <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // One settle cycle after the last iteration keeps the
                    // accept-to-valid latency at WIDTH+2 like the multipliers.
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end else begin
                        if (!diff[WIDTH]) begin
                            prem <= diff[WIDTH-1:0];
                            dvd  <= {dvd[WIDTH-2:0], 1'b1};
                        end else begin
                            prem <= shifted[WIDTH-1:0];
                            dvd  <= {dvd[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (zero_b) begin
                        quot_r <= '1;
                    end else begin
                        quot_r <= neg_q ? (~dvd + 1'b1) : dvd;
                    end
                    div0_r <= zero_b;
`ifdef MATRIXMUL_3_SDIV_REM_EN
                    // With a zero divisor prem ends as |din0|, so the sign fix
                    // reproduces the original dividend.
                    rem_r  <= neg_r ? (~prem + 1'b1) : prem;
`endif
                    vld_r  <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (bus.dout_ack) begin
                        vld_r <= 1'b0;
                        rdy_r <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.din_rdy  = rdy_r;
    assign bus.dout_vld = vld_r;
    assign bus.quot     = quot_r;
    assign bus.div0     = div0_r;
`ifdef MATRIXMUL_3_SDIV_REM_EN
    assign bus.rem      = rem_r;
`endif
    assign state_dbg    = state;

endmodule

// File: tb/tb_matrixmul_3_sdiv_32s_32s_32_seq.sv
// Self-checking bench for the matrixmul_3 signed divider (table, corner and random ops).
// rem is compared only when MATRIXMUL_3_SDIV_REM_EN is defined.
module tb_matrixmul_3_sdiv_32s_32s_32_seq;
    localparam int W     = 32;
    localparam int LAT   = W + 2;
    localparam int SB_W  = 2 * W + 1;

    logic       clk;
    logic       reset;
    logic       ce;
    logic [1:0] state_dbg;

    matrixmul_3_sdiv_32s_32s_32_seq_if #(.WIDTH(W)) bus ();

    matrixmul_3_sdiv_32s_32s_32_seq #(.ID(1), .WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .bus      (bus),
        .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;

    logic [SB_W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         d;
    } vec_t;

    vec_t vecs[12];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain C-style truncating division on 64-bit integers.
    function automatic logic [SB_W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint la;
        longint lb;
        logic [W-1:0] q;
        logic [W-1:0] r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (lb == 0) return {1'b1, {W{1'b1}}, a};
        q = W'(la / lb);
        r = W'(la % lb);
        return {1'b0, q, r};
    endfunction

    // Drives one operation, waits for the result, compares against the head
    // of exp_q, then acknowledges after 'hold' extra cycles.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input int stall_at, input int stall_len, input string name);
        int lat;
        int waitc;
        logic rdy_hi;
        logic [SB_W-1:0] e;
        logic [W-1:0] q0;
        waitc = 0;
        while (!bus.din_rdy && waitc < 100) begin
            tick();
            waitc++;
        end
        if (!bus.din_rdy) begin
            checks++; errors++;
            $display("FAIL %s_rdy_timeout actual=0 required=1", name);
        end
        bus.din0 = a;
        bus.din1 = b;
        bus.din_vld = 1'b1;
        tick();
        bus.din_vld = 1'b0;
        bus.din0 = $urandom;
        bus.din1 = $urandom;
        lat = 0;
        rdy_hi = 1'b0;
        while (!bus.dout_vld && lat < 200) begin
            tick();
            lat++;
            if (stall_len > 0 && lat == stall_at) ce = 1'b0;
            if (stall_len > 0 && lat == stall_at + stall_len) ce = 1'b1;
            if (bus.din_rdy) rdy_hi = 1'b1;
        end
        check({name, "_latency"}, W'(lat), W'(LAT + stall_len));
        check({name, "_rdy_busy"}, W'(rdy_hi), W'(0));
        e = exp_q.pop_front();
        check({name, "_quot"}, bus.quot, e[2*W-1:W]);
        check({name, "_div0"}, W'(bus.div0), W'(e[2*W]));
`ifdef MATRIXMUL_3_SDIV_REM_EN
        check({name, "_rem"}, bus.rem, e[W-1:0]);
`endif
        q0 = bus.quot;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({name, "_hold"}, {bus.quot[W-3:0], bus.dout_vld, bus.din_rdy},
                  {q0[W-3:0], 1'b1, 1'b0});
        end
        bus.dout_ack = 1'b1;
        tick();
        bus.dout_ack = 1'b0;
        check({name, "_vld_after_ack"}, W'(bus.dout_vld), W'(0));
        check({name, "_rdy_after_ack"}, W'(bus.din_rdy), W'(1));
        check({name, "_quot_kept"}, bus.quot, q0);
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] q, input logic [W-1:0] r, input logic d);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.d = d;
        return v;
    endfunction

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        vecs[0]  = mk(32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
        vecs[1]  = mk(-32'sd100,    32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        vecs[2]  = mk(32'd100,      -32'sd7,      32'hFFFFFFF2, 32'd2,        1'b0);
        vecs[3]  = mk(-32'sd100,    -32'sd7,      32'd14,       32'hFFFFFFFE, 1'b0);
        vecs[4]  = mk(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
        vecs[5]  = mk(32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1);
        vecs[6]  = mk(32'd0,        32'd9,        32'd0,        32'd0,        1'b0);
        vecs[7]  = mk(32'd7,        -32'sd2,      32'hFFFFFFFD, 32'd1,        1'b0);
        vecs[8]  = mk(-32'sd7,      32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        vecs[9]  = mk(-32'sd5,      32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
        vecs[10] = mk(32'h80000000, 32'd1,        32'h80000000, 32'd0,        1'b0);
        vecs[11] = mk(32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0);

        reset = 1'b0;
        ce = 1'b1;
        bus.din_vld = 1'b0;
        bus.din0 = '0;
        bus.din1 = '0;
        bus.dout_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("reset_rdy", W'(bus.din_rdy), W'(1));
        check("reset_vld", W'(bus.dout_vld), W'(0));
        check("reset_quot", bus.quot, W'(0));
        check("reset_div0", W'(bus.div0), W'(0));

        // stray ack outside DONE must do nothing
        bus.dout_ack = 1'b1;
        tick();
        bus.dout_ack = 1'b0;
        check("stray_ack_rdy", W'(bus.din_rdy), W'(1));

        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].d, vecs[i].q, vecs[i].r});
            run_op(vecs[i].a, vecs[i].b, 0, 0, 0, $sformatf("vec%0d", i));
        end

        exp_q.push_back(ref_div(32'd100, 32'd7));
        run_op(32'd100, 32'd7, 0, 10, 3, "stall");

        exp_q.push_back(ref_div(32'd100, 32'd7));
        run_op(32'd100, 32'd7, 10, 0, 0, "hold_ack");

        exp_q.push_back({1'b0, 32'd3, 32'd1});
        run_op(32'd7, 32'd2, 0, 0, 0, "b2b_a");
        exp_q.push_back({1'b0, 32'd2, 32'd1});
        run_op(32'd9, 32'd4, 0, 0, 0, "b2b_b");

        // reset in the middle of CALC discards the operation
        bus.din0 = 32'd1000;
        bus.din1 = 32'd3;
        bus.din_vld = 1'b1;
        tick();
        bus.din_vld = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset_rdy", W'(bus.din_rdy), W'(1));
        check("midreset_vld", W'(bus.dout_vld), W'(0));
        check("midreset_quot", bus.quot, W'(0));
        exp_q.push_back({1'b0, 32'd3, 32'd2});
        run_op(32'd20, 32'd6, 0, 0, 0, "after_reset");

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = W'($urandom_range(1, 40));
                2: rb = -W'($urandom_range(1, 40));
                default: rb = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(1, 1000));
            endcase
            if (i % 6 == 5) ra = -W'($urandom_range(0, 50));
            exp_q.push_back(ref_div(ra, rb));
            run_op(ra, rb, $urandom_range(0, 2), $urandom_range(2, 30),
                   (i % 4 == 0) ? $urandom_range(1, 4) : 0, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
